prog_loader: RTL and testbench

Byte-stream program loader that writes a framed program image into the CPU's 256×8 instruction/data memory through a write port. It holds the CPU stalled while the image is loaded. It sits between a host byte source (UART receiver or test harness) and the memory array the CPU fetches from. Each frame carries a start address, a length, the data bytes and an optional checksum; the loader reports success or failure per frame.

---
 rtl/cpu2_pkg.sv | 24 ++
 rtl/prog_loader.sv | 142 ++++++++++++++
 tb/tb_prog_loader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cpu2_pkg.sv
// Shared CPU2 definitions: memory geometry, loader state encoding and the frame SYNC byte.
package cpu2_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int MEM_AW    = 8;
  localparam int MEM_DW    = 8;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_ADDR,
    LD_LEN,
    LD_DATA,
    LD_CHK,
    LD_FIN
  } ld_state_e;

  // A length byte of zero encodes a full 2^w-byte frame.
  function automatic logic [MEM_DW:0] len_decode(input logic [MEM_DW-1:0] b);
    return (b == '0) ? {1'b1, {MEM_DW{1'b0}}} : {1'b0, b};
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream program loader (SYNC, ADDR, LEN, data, CHK) into the CPU memory write port.
// Define PROG_LOADER_CHECKSUM_EN to expect and verify the trailing CHK byte.
module prog_loader
  import cpu2_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = DATA_W + 1;

  ld_state_e         state_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic [CNT_W-1:0]  len_d;

  assign accept = in_valid && in_ready_q;
  assign len_d  = (in_data == '0) ? CNT_W'(1) << DATA_W : CNT_W'(in_data);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] sum_d;
  logic              error_q;

  assign sum_d = acc_q + in_data;
  assign error = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      error_q <= 1'b0;
    end else if (accept) begin
      case (state_q)
        LD_IDLE: if (in_data == DATA_W'(SYNC_BYTE)) begin
          acc_q   <= '0;
          error_q <= 1'b0;
        end
        LD_ADDR, LD_LEN, LD_DATA: acc_q <= sum_d;
        LD_CHK: begin
          acc_q <= sum_d;
          if (sum_d != '0) error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign error = 1'b0;
`endif

  // Single FSM; every output is registered so the memory port sees clean strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LD_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      in_ready_q <= 1'b1;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        LD_IDLE: if (accept && in_data == DATA_W'(SYNC_BYTE)) begin
          state_q    <= LD_ADDR;
          cpu_hold_q <= 1'b1;
        end
        LD_ADDR: if (accept) begin
          addr_q  <= ADDR_W'(in_data);
          state_q <= LD_LEN;
        end
        LD_LEN: if (accept) begin
          cnt_q   <= len_d;
          state_q <= LD_DATA;
        end
        LD_DATA: if (accept) begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= addr_q;
          mem_wdata_q <= in_data;
          addr_q      <= addr_q + 1'b1;
          cnt_q       <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_q <= LD_CHK;
`else
            state_q    <= LD_FIN;
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
`endif
          end
        end
        LD_CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (accept) begin
            state_q    <= LD_FIN;
            in_ready_q <= 1'b0;
            done_q     <= (sum_d == '0);
          end
`else
          state_q <= LD_FIN;
`endif
        end
        LD_FIN: begin
          state_q    <= LD_IDLE;
          cpu_hold_q <= 1'b0;
        end
        default: state_q <= LD_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of frames plus hand sequences for noise, stall, reset and LEN=0.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mem_we, cpu_hold, done, error;
  logic [7:0] mem_addr, mem_wdata;

  prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int first_wr = -1;
  int last_wr = -1;
  logic [7:0] tbmem [256];

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      tbmem[mem_addr] = mem_wdata;
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      check("hold_during_write", {31'd0, cpu_hold}, 32'd1);
    end
    if (done) done_cnt++;
  end

  task automatic clr_stats();
    wr_cnt = 0; done_cnt = 0; first_wr = -1; last_wr = -1;
  endtask

  // Called on a negedge; returns on the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {25'd0, in_ready, mem_we, cpu_hold, done, error, |mem_addr, |mem_wdata}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]       addr;
    int               len;
    logic [3:0][7:0]  d;
    logic [7:0]       chk;
    bit               ok;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic [7:0] sum;
    int bad;

    vt[0] = '{addr: 8'h00, len: 3, d: {8'h00, 8'h33, 8'h22, 8'h11}, chk: 8'h97, ok: 1'b1};
    vt[1] = '{addr: 8'hFE, len: 3, d: {8'h00, 8'h03, 8'h02, 8'h01}, chk: 8'hF9, ok: 1'b1};
    vt[2] = '{addr: 8'h10, len: 1, d: {8'h00, 8'h00, 8'h00, 8'hAA}, chk: 8'h00, ok: 1'b0};
    vt[3] = '{addr: 8'h40, len: 2, d: {8'h00, 8'h00, 8'h5A, 8'hA5}, chk: 8'hBF, ok: 1'b1};
    vt[4] = '{addr: 8'h80, len: 4, d: {8'h04, 8'h03, 8'h02, 8'h01}, chk: 8'h72, ok: 1'b1};
    for (int i = 0; i < 256; i++) tbmem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    for (int r = 0; r < 5; r++) begin
      bit exp_ok;
      exp_ok = CHK_EN ? vt[r].ok : 1'b1;
      clr_stats();
      send_byte(8'hA5);
      check($sformatf("r%0d_hold_after_sync", r), {31'd0, cpu_hold}, 32'd1);
      check($sformatf("r%0d_err_cleared", r), {31'd0, error}, 32'd0);
      send_byte(vt[r].addr);
      send_byte(vt[r].len[7:0]);
      for (int i = 0; i < vt[r].len; i++) send_byte(vt[r].d[i]);
      if (CHK_EN) send_byte(vt[r].chk);
      check($sformatf("r%0d_fin_ready", r), {31'd0, in_ready}, 32'd0);
      check($sformatf("r%0d_fin_hold", r), {31'd0, cpu_hold}, 32'd1);
      check($sformatf("r%0d_fin_done", r), {31'd0, done}, {31'd0, exp_ok});
      @(negedge clk);
      check($sformatf("r%0d_idle_hold", r), {31'd0, cpu_hold}, 32'd0);
      check($sformatf("r%0d_idle_ready", r), {31'd0, in_ready}, 32'd1);
      repeat (4) @(negedge clk);
      check($sformatf("r%0d_wr_cnt", r), wr_cnt, vt[r].len);
      check($sformatf("r%0d_b2b", r), last_wr - first_wr, vt[r].len - 1);
      for (int i = 0; i < vt[r].len; i++)
        check($sformatf("r%0d_mem%0d", r, i), {24'd0, tbmem[8'(vt[r].addr + i)]}, {24'd0, vt[r].d[i]});
      check($sformatf("r%0d_done_cnt", r), done_cnt, exp_ok ? 1 : 0);
      check($sformatf("r%0d_error_sticky", r), {31'd0, error}, {31'd0, !exp_ok});
    end

    // Noise before SYNC, then a frame with valid gaps.
    clr_stats();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    @(negedge clk);
    check("noise_no_writes", wr_cnt, 0);
    check("noise_no_hold", {31'd0, cpu_hold}, 32'd0);
    send_byte(8'hA5); repeat (3) @(negedge clk);
    send_byte(8'h20); repeat (2) @(negedge clk);
    send_byte(8'h02); repeat (5) @(negedge clk);
    check("stall_hold", {31'd0, cpu_hold}, 32'd1);
    check("stall_no_writes", wr_cnt, 0);
    send_byte(8'h77); repeat (4) @(negedge clk);
    check("stall_one_write", wr_cnt, 1);
    send_byte(8'h88);
    if (CHK_EN) begin repeat (2) @(negedge clk); send_byte(8'hDF); end
    repeat (4) @(negedge clk);
    check("stall_wr_cnt", wr_cnt, 2);
    check("stall_mem20", {24'd0, tbmem[8'h20]}, 32'h77);
    check("stall_mem21", {24'd0, tbmem[8'h21]}, 32'h88);
    check("stall_done", done_cnt, 1);

    // Reset after the second data byte of a LEN=4 frame.
    clr_stats();
    send_byte(8'hA5); send_byte(8'h30); send_byte(8'h04);
    send_byte(8'hDE); send_byte(8'hAD);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_ready", {31'd0, in_ready}, 32'd1);
    check("midreset_kept30", {24'd0, tbmem[8'h30]}, 32'hDE);
    check("midreset_kept31", {24'd0, tbmem[8'h31]}, 32'hAD);
    clr_stats();
    send_byte(8'hA5); send_byte(8'h30); send_byte(8'h04);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    if (CHK_EN) send_byte(8'hC2);
    repeat (4) @(negedge clk);
    check("post_reset_wr_cnt", wr_cnt, 4);
    check("post_reset_mem", {tbmem[8'h30], tbmem[8'h31], tbmem[8'h32], tbmem[8'h33]}, 32'h01020304);
    check("post_reset_done", done_cnt, 1);

    // LEN=0 means a full 256-byte image.
    clr_stats();
    sum = 8'h00;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i) ^ 8'h5A);
      sum = sum + (8'(i) ^ 8'h5A);
    end
    if (CHK_EN) send_byte(8'h00 - sum);
    repeat (4) @(negedge clk);
    check("len0_wr_cnt", wr_cnt, 256);
    check("len0_b2b", last_wr - first_wr, 255);
    bad = 0;
    for (int i = 0; i < 256; i++) if (tbmem[i] !== (8'(i) ^ 8'h5A)) bad++;
    check("len0_mem_bad", bad, 0);
    check("len0_done", done_cnt, 1);
    check("len0_error", {31'd0, error}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
